// File: rtl/bsg_fpu_pack.sv
// bsg_fpu_pack: two-stage IEEE-754 packer at the tail of the FPU pipes.
// S1 rounds the incoming fraction to nearest-even; S2 classifies the rounded
// result (NaN / inf / zero / underflow / overflow / normal) and registers the
// packed word with its exception flags.
module bsg_fpu_pack #(
    parameter int e_p = 11,
    parameter int m_p = 52
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               v_i,
    output logic               ready_o,
    input  logic               sign_i,
    input  logic [e_p+1:0]     exp_i,
    input  logic [m_p+2:0]     man_i,
    input  logic               zero_i,
    input  logic               infty_i,
    input  logic               nan_i,
    input  logic               sig_nan_i,

    output logic               v_o,
    input  logic               yumi_i,
    output logic [e_p+m_p:0]   z_o,
    output logic               invalid_o,
    output logic               overflow_o,
    output logic               underflow_o,
    output logic               inexact_o
);

    localparam logic [e_p+1:0] exp_one_lp = (e_p+2)'(1);
    localparam logic [e_p+1:0] exp_max_lp = (e_p+2)'((1 << e_p) - 1);

    // S1 state
    logic               s1_v_q, s1_v_d;
    logic               s1_sign_q;
    logic [e_p+1:0]     s1_exp_q, s1_exp_d;
    logic [m_p-1:0]     s1_frac_q, s1_frac_d;
    logic               s1_inexact_q, s1_inexact_d;
    logic               s1_zero_q, s1_infty_q, s1_nan_q, s1_sig_nan_q;

    // S2 state
    logic               s2_v_q, s2_v_d;
    logic [e_p+m_p:0]   s2_z_q, s2_z_d;
    logic               s2_invalid_q, s2_invalid_d;
    logic               s2_overflow_q, s2_overflow_d;
    logic               s2_underflow_q, s2_underflow_d;
    logic               s2_inexact_q, s2_inexact_d;

    logic               s1_adv;
    logic               s1_load;
    logic               accept;
    logic               round_up;
    logic [m_p:0]       frac_r;

    // Handshake: S2 frees up when empty or consumed; S1 refills behind it.
    assign s1_adv  = ~s2_v_q | yumi_i;
    assign s1_load = ~s1_v_q | s1_adv;
    assign ready_o = s1_load;
    assign accept  = v_i & ready_o;

    // S1 next state: round-to-nearest-even with carry into the exponent.
    always_comb begin
        round_up     = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
        s1_inexact_d = |man_i[2:0];
        frac_r       = {1'b0, man_i[m_p+2:3]} + {{m_p{1'b0}}, round_up};
        s1_frac_d    = frac_r[m_p-1:0];
        s1_exp_d     = frac_r[m_p] ? (exp_i + exp_one_lp) : exp_i;
        s1_v_d       = s1_load ? v_i : s1_v_q;
    end

    // S1 register: holds while S2 is stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_v_q       <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_inexact_q <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_infty_q   <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_sig_nan_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            if (accept) begin
                s1_sign_q    <= sign_i;
                s1_exp_q     <= s1_exp_d;
                s1_frac_q    <= s1_frac_d;
                s1_inexact_q <= s1_inexact_d;
                s1_zero_q    <= zero_i;
                s1_infty_q   <= infty_i;
                s1_nan_q     <= nan_i;
                s1_sig_nan_q <= sig_nan_i;
            end
        end
    end

    // S2 next state: classify the rounded S1 result, highest priority first.
    always_comb begin
        s2_z_d         = {s1_sign_q, s1_exp_q[e_p-1:0], s1_frac_q};
        s2_invalid_d   = 1'b0;
        s2_overflow_d  = 1'b0;
        s2_underflow_d = 1'b0;
        s2_inexact_d   = s1_inexact_q;
        s2_v_d         = s1_adv ? s1_v_q : s2_v_q;
        if (s1_nan_q) begin
            s2_z_d       = {1'b0, {e_p{1'b1}}, 1'b1, {(m_p-1){1'b0}}};
            s2_invalid_d = s1_sig_nan_q;
            s2_inexact_d = 1'b0;
        end else if (s1_infty_q) begin
            s2_z_d       = {s1_sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
            s2_inexact_d = 1'b0;
        end else if (s1_zero_q) begin
            s2_z_d       = {s1_sign_q, {(e_p+m_p){1'b0}}};
            s2_inexact_d = 1'b0;
        end else if ($signed(s1_exp_q) <= $signed({(e_p+2){1'b0}})) begin
            // No denormal support: anything at or below exponent zero flushes.
            s2_z_d         = {s1_sign_q, {(e_p+m_p){1'b0}}};
            s2_underflow_d = 1'b1;
            s2_inexact_d   = 1'b1;
        end else if ($signed(s1_exp_q) >= $signed(exp_max_lp)) begin
            s2_z_d        = {s1_sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
            s2_overflow_d = 1'b1;
            s2_inexact_d  = 1'b1;
        end
    end

    // S2 register: only loads real items so z_o and flags stay put otherwise.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_v_q         <= 1'b0;
            s2_z_q         <= '0;
            s2_invalid_q   <= 1'b0;
            s2_overflow_q  <= 1'b0;
            s2_underflow_q <= 1'b0;
            s2_inexact_q   <= 1'b0;
        end else begin
            s2_v_q <= s2_v_d;
            if (s1_adv & s1_v_q) begin
                s2_z_q         <= s2_z_d;
                s2_invalid_q   <= s2_invalid_d;
                s2_overflow_q  <= s2_overflow_d;
                s2_underflow_q <= s2_underflow_d;
                s2_inexact_q   <= s2_inexact_d;
            end
        end
    end

    assign v_o         = s2_v_q;
    assign z_o         = s2_z_q;
    assign invalid_o   = s2_invalid_q;
    assign overflow_o  = s2_overflow_q;
    assign underflow_o = s2_underflow_q;
    assign inexact_o   = s2_inexact_q;

endmodule

// File: tb/tb_bsg_fpu_pack.sv
// Testbench for bsg_fpu_pack (double precision): directed cases with literal
// expectations, a backpressure scenario, randomized traffic against an
// arithmetic reference model, and a mid-flight reset.
module tb_bsg_fpu_pack;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic        sign_i;
    logic [12:0] exp_i;
    logic [54:0] man_i;
    logic        zero_i, infty_i, nan_i, sig_nan_i;
    logic        v_o;
    logic        yumi_i;
    logic [63:0] z_o;
    logic        invalid_o, overflow_o, underflow_o, inexact_o;

    bsg_fpu_pack #(.e_p(11), .m_p(52)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_o),
        .sign_i(sign_i), .exp_i(exp_i), .man_i(man_i),
        .zero_i(zero_i), .infty_i(infty_i), .nan_i(nan_i), .sig_nan_i(sig_nan_i),
        .v_o(v_o), .yumi_i(yumi_i), .z_o(z_o),
        .invalid_o(invalid_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .inexact_o(inexact_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [67:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [67:0] prev_out   = '0;
    wire  [67:0] out_w = {z_o, invalid_o, overflow_o, underflow_o, inexact_o};

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: {z[63:0], invalid, overflow, underflow, inexact}
    function automatic logic [67:0] model(input logic s, input logic [12:0] e_in,
                                          input logic [54:0] m, input logic zr,
                                          input logic inf, input logic nan, input logic snan);
        longint e;
        longint f;
        int     grs;
        logic   inx;
        e   = longint'($signed(e_in));
        f   = longint'(m[54:3]);
        grs = int'(m[2:0]);
        if (nan) return {64'h7FF8000000000000, snan, 3'b000};
        if (inf) return {s, 11'h7FF, 52'h0, 4'h0};
        if (zr)  return {s, 63'h0, 4'h0};
        inx = (grs != 0);
        if (grs > 4 || (grs == 4 && (f % 2) == 1)) f = f + 1;
        if (f == (longint'(1) << 52)) begin
            f = 0;
            e = e + 1;
            if (e > 4095) e = e - 8192;
        end
        if (e <= 0)    return {s, 63'h0, 4'b0011};
        if (e >= 2047) return {s, 11'h7FF, 52'h0, 4'b0101};
        return {s, 11'(e), 52'(f), 3'b000, inx};
    endfunction

    // Single compare process: ready vs occupancy, stall stability, in-order results.
    always @(negedge clk_i) begin
        if (reset_i) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("ready", 72'(ready_o), 72'((exp_q.size() < 2) || yumi_i));
            if (prev_stall)
                check("stall_hold", 72'({v_o, out_w}), 72'({1'b1, prev_out}));
            if (v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got %h, expected no output", out_w);
                end else begin
                    check("result", 72'(out_w), 72'(exp_q.pop_front()));
                end
            end
            if (v_i && ready_o)
                exp_q.push_back(model(sign_i, exp_i, man_i, zero_i, infty_i, nan_i, sig_nan_i));
            prev_stall = v_o && !yumi_i;
            prev_out   = out_w;
        end
    end

    task automatic rand_item(input bit allow_class);
        logic [63:0] tmp;
        int          sel;
        tmp    = {$urandom(), $urandom()};
        man_i  = tmp[54:0];
        if ($urandom_range(0, 3) == 0) man_i[54:3] = '1;
        sign_i = 1'($urandom_range(0, 1));
        sel    = int'($urandom_range(0, 5));
        case (sel)
            0: exp_i = 13'(1023 + int'($urandom_range(0, 6)) - 3);
            1: exp_i = 13'(2040 + int'($urandom_range(0, 10)));
            2: exp_i = 13'(int'($urandom_range(0, 6)) - 3);
            3: exp_i = 13'($urandom());
            4: exp_i = 13'(4088 + int'($urandom_range(0, 7)));
            default: exp_i = 13'($urandom_range(1, 2046));
        endcase
        zero_i    = allow_class && ($urandom_range(0, 15) == 0);
        infty_i   = allow_class && ($urandom_range(0, 15) == 0);
        nan_i     = allow_class && ($urandom_range(0, 15) == 0);
        sig_nan_i = allow_class && ($urandom_range(0, 3) == 0);
    endtask

    task automatic directed(input string name, input logic s, input logic [12:0] e,
                            input logic [54:0] m, input logic [3:0] cls,
                            input logic [63:0] zexp, input logic [3:0] fexp);
        int lat;
        @(posedge clk_i); #1;
        sign_i = s; exp_i = e; man_i = m;
        {zero_i, infty_i, nan_i, sig_nan_i} = cls;
        v_i = 1'b1; yumi_i = 1'b0;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        lat = 1;
        while (!v_o && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({name, "_latency"}, 72'(lat), 72'(2));
        check(name, 72'(out_w), 72'({zexp, fexp}));
        yumi_i = 1'b1;
        @(posedge clk_i); #1;
        yumi_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i); #1;
            v_i    = 1'b0;
            yumi_i = v_o;
            if (exp_q.size() == 0 && !v_o) break;
        end
        yumi_i = 1'b0;
        check("drain", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, retired, last_c;
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
        sign_i = 1'b0; exp_i = '0; man_i = '0;
        zero_i = 1'b0; infty_i = 1'b0; nan_i = 1'b0; sig_nan_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        check("reset_state", 72'({v_o, ready_o, out_w}), 72'({1'b0, 1'b1, 68'h0}));

        directed("one",        1'b0, 13'd1023, {52'h0, 3'b000}, 4'b0000, 64'h3FF0000000000000, 4'b0000);
        directed("tie_odd",    1'b0, 13'd1023, {52'h1, 3'b100}, 4'b0000, 64'h3FF0000000000002, 4'b0001);
        directed("tie_even",   1'b0, 13'd1023, {52'h2, 3'b100}, 4'b0000, 64'h3FF0000000000002, 4'b0001);
        directed("carry",      1'b0, 13'd1023, {{52{1'b1}}, 3'b110}, 4'b0000, 64'h4000000000000000, 4'b0001);
        directed("carry_ovf",  1'b0, 13'd2046, {{52{1'b1}}, 3'b110}, 4'b0000, 64'h7FF0000000000000, 4'b0101);
        directed("snan",       1'b1, 13'd1023, {52'h5, 3'b000}, 4'b0011, 64'h7FF8000000000000, 4'b1000);
        directed("neg_inf",    1'b1, 13'd1023, {52'h5, 3'b000}, 4'b0100, 64'hFFF0000000000000, 4'b0000);
        directed("flush",      1'b0, 13'h1FFB, {52'h12345, 3'b000}, 4'b0000, 64'h0000000000000000, 4'b0011);

        // Backpressure: 6 back-to-back items, consumer stalls for 4 cycles.
        sent = 0; retired = 0; last_c = -1;
        for (int c = 0; c < 40 && retired < 6; c++) begin
            @(posedge clk_i); #1;
            v_i = (sent < 6);
            if (v_i) rand_item(1'b0);
            yumi_i = (c >= 4) && v_o;
            @(negedge clk_i);
            if (c == 2 || c == 3) check("bp_ready_low", 72'(ready_o), 72'(0));
            if (v_i && ready_o) sent++;
            if (c >= 4) begin
                if (v_o && yumi_i) retired++;
                else if (retired < 6) check("bp_one_per_cycle", 72'(v_o && yumi_i), 72'(1));
            end
            last_c = c;
        end
        v_i = 1'b0; yumi_i = 1'b0;
        check("bp_count", 72'(retired), 72'(6));
        check("bp_last_cycle", 72'(last_c), 72'(9));

        // Randomized traffic with random consumer stalls.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i); #1;
            v_i    = ($urandom_range(0, 9) < 7);
            rand_item(1'b1);
            yumi_i = v_o && ($urandom_range(0, 9) < 7);
        end
        drain();

        // Reset with two items in flight.
        @(posedge clk_i); #1;
        yumi_i = 1'b0; v_i = 1'b1; rand_item(1'b0);
        @(posedge clk_i); #1;
        rand_item(1'b0);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        check("post_reset", 72'({v_o, ready_o, out_w}), 72'({1'b0, 1'b1, 68'h0}));
        for (int c = 0; c < 6; c++) begin
            yumi_i = v_o;
            @(posedge clk_i); #1;
            check("no_stale_output", 72'(v_o), 72'(0));
        end
        yumi_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsg_fpu_pack.md
Name: bsg_fpu_pack

Overview:
- Pipelined IEEE-754 packer; the inverse of the FPU preprocess unpacker.
- Takes sign, a wide biased exponent, a fraction with guard/round/sticky bits, and class flags from an FPU datapath.
- Rounds to nearest-even, detects overflow and underflow, selects special encodings, and emits a packed (1+e_p+m_p)-bit float.
- Sits at the tail of the FPU add/mul pipes; valid/ready in, valid/yumi out.

Parameters:
- e_p, 11: exponent field width.
- m_p, 52: mantissa (fraction) field width.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous active-high reset.
- v_i, input, 1: input valid.
- ready_o, output, 1: input accepted when v_i & ready_o.
- sign_i, input, 1: result sign.
- exp_i, input, e_p+2: two's-complement biased exponent. Range -2^(e_p+1) .. 2^(e_p+1)-1.
- man_i, input, m_p+3: [m_p+2:3] fraction with hidden bit implicit, [2] guard, [1] round, [0] sticky.
- zero_i, input, 1: result is zero.
- infty_i, input, 1: result is infinity.
- nan_i, input, 1: result is NaN.
- sig_nan_i, input, 1: a signaling NaN operand was consumed.
- v_o, output, 1: output valid.
- yumi_i, input, 1: consumer takes output. Legal only when v_o=1.
- z_o, output, 1+e_p+m_p: packed float {sign, exp, frac}.
- invalid_o, output, 1: IEEE invalid flag.
- overflow_o, output, 1: overflow flag.
- underflow_o, output, 1: underflow flag.
- inexact_o, output, 1: inexact flag.

Behaviour:
- Single clock. Reset is synchronous, active-high, on reset_i.
- Reset state: both stage valids 0, v_o=0. z_o and all flags 0. ready_o=1 in the first cycle after reset deasserts.
- Reset mid-operation discards in-flight items; no output for them.
- Two registered stages, S1 and S2. v_o is S2 valid.
- S1 advances when S2 is empty or yumi_i=1. S1 loads when S1 is empty or S1 advances.
- ready_o = ~S1_v | S1_advance. This is combinational from yumi_i; there is no path from v_i to ready_o.
- Latency: 2 cycles from accept to v_o with no stall; throughput 1 per cycle.
- Backpressure holds both stages stable with no loss or duplication. Simultaneous yumi_i and v_i accepts the new item and retires the old one in the same edge.
- S1 (rounding):
  - lsb = man_i[3]; g, r, s = man_i[2:0].
  - round_up = g & (r | s | lsb). inexact_raw = g | r | s.
  - frac_r = frac + round_up, width m_p+1.
  - On carry out: frac=0, exp=exp_i+1, held at e_p+2 bits. Otherwise exp=exp_i.
  - Register sign, exp, frac, inexact_raw and the class flags.
- S2 (classification and pack). Priority is highest first:
  1. nan: z = canonical quiet NaN {0, all-ones exp, 1 followed by m_p-1 zeros}. invalid_o=sig_nan_i. Other flags 0.
  2. infty: z = {sign, all-ones, 0}. All flags 0.
  3. zero: z = {sign, 0, 0}. All flags 0.
  4. exp <= 0, signed: flush to zero. z = {sign, 0, 0}, underflow_o=1, inexact_o=1. Denormals are not produced.
  5. exp >= 2^e_p - 1: z = {sign, all-ones, 0}, overflow_o=1, inexact_o=1.
  6. Otherwise: z = {sign, exp[e_p-1:0], frac[m_p-1:0]}, inexact_o=inexact_raw.
- Flags are valid only with v_o and are held with z_o during a stall.
- Conflicting class flags resolve by the priority above; this is not an error.

Test Plan:
- sign=0, exp=1023, frac=0, grs=000 -> z_o=0x3FF0000000000000, all flags 0, v_o exactly 2 cycles after accept.
- Tie-to-even: exp=1023, frac=0x0000000000001, grs=100 -> 0x3FF0000000000002, inexact=1. With frac=0x0000000000002, grs=100 -> 0x3FF0000000000002, inexact=1.
- Rounding carry: exp=1023, frac all-ones, grs=110 -> 0x4000000000000000, inexact=1. Same with exp=2046 -> 0x7FF0000000000000, overflow=1, inexact=1.
- Specials: nan_i=1 with sig_nan_i=1, sign=1 -> 0x7FF8000000000000, invalid=1. infty_i=1, sign=1 -> 0xFFF0000000000000. exp_i=-5, non-zero frac -> 0x0000000000000000, underflow=1, inexact=1.
- Backpressure: stream 6 back-to-back items while holding yumi_i=0 for 4 cycles. Required: ready_o drops after 2 accepted, outputs appear in order with none lost or duplicated, z_o is stable while stalled, and with yumi_i held at 1, one result per cycle.
- Reset asserted with 2 items in flight -> next cycle v_o=0, z_o=0, ready_o=1; the stale items never emerge.
